// File: rtl/router_reg_param.sv
// router_reg_param: router input register stage -- header latch, one-word park/replay,
// running XOR parity and parity-error flag. Define ROUTER_REG_LEN_CHECK_EN to add the payload-length check.
module router_reg_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int NUM_PORTS = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_packet_valid,
  output logic              err,
  output logic              len_err
);

  localparam int              LEN_W     = DATA_W - ADDR_W;
  // One extra bit so NUM_PORTS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] PORTS_LIM = (ADDR_W + 1)'(NUM_PORTS);

  logic [DATA_W-1:0] r_hdr;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_int_par;
  logic [DATA_W-1:0] r_pkt_par;
  logic [DATA_W-1:0] r_dout;
  logic              r_parity_done;
  logic              r_low_packet_valid;
  logic              r_err;

  logic w_addr_ok;
  logic w_pay_accept;
  logic w_par_from_din;
  logic w_par_from_hold;

  assign w_addr_ok       = {1'b0, data_in[ADDR_W-1:0]} < PORTS_LIM;
  assign w_pay_accept    = ld_state && pkt_valid && !full_state;
  assign w_par_from_din  = ld_state && !pkt_valid && !fifo_full;
  assign w_par_from_hold = laf_state && r_low_packet_valid && !r_parity_done;

  always_ff @(posedge clock) begin
    if (reset)                                r_hdr <= '0;
    else if (detect_add && pkt_valid && w_addr_ok) r_hdr <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset)                       r_dout <= '0;
    else if (lfd_state)              r_dout <= r_hdr;
    else if (ld_state && !fifo_full) r_dout <= data_in;
    else if (laf_state)              r_dout <= r_hold;
  end

  always_ff @(posedge clock) begin
    if (reset)                      r_hold <= '0;
    else if (ld_state && fifo_full) r_hold <= data_in;
  end

  // A parked payload word is folded in when it arrives, so its replay must not XOR it again.
  always_ff @(posedge clock) begin
    if (reset)             r_int_par <= '0;
    else if (detect_add)   r_int_par <= '0;
    else if (lfd_state)    r_int_par <= r_int_par ^ r_hdr;
    else if (w_pay_accept) r_int_par <= r_int_par ^ data_in;
  end

  always_ff @(posedge clock) begin
    if (reset)                r_pkt_par <= '0;
    else if (w_par_from_din)  r_pkt_par <= data_in;
    else if (w_par_from_hold) r_pkt_par <= r_hold;
  end

  always_ff @(posedge clock) begin
    if (reset)                                  r_parity_done <= 1'b0;
    else if (detect_add)                        r_parity_done <= 1'b0;
    else if (w_par_from_din || w_par_from_hold) r_parity_done <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)                      r_low_packet_valid <= 1'b0;
    else if (rst_int_reg)           r_low_packet_valid <= 1'b0;
    else if (ld_state && !pkt_valid) r_low_packet_valid <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)              r_err <= 1'b0;
    else if (detect_add)    r_err <= 1'b0;
    else if (r_parity_done) r_err <= (r_int_par != r_pkt_par);
  end

`ifdef ROUTER_REG_LEN_CHECK_EN
  logic [LEN_W-1:0] r_pay_cnt;
  logic             r_len_err;

  // Saturating count: a long packet must not wrap back onto a small length field.
  always_ff @(posedge clock) begin
    if (reset)                                 r_pay_cnt <= '0;
    else if (detect_add)                       r_pay_cnt <= '0;
    else if (w_pay_accept && (r_pay_cnt != '1)) r_pay_cnt <= r_pay_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)              r_len_err <= 1'b0;
    else if (detect_add)    r_len_err <= 1'b0;
    else if (r_parity_done) r_len_err <= (r_pay_cnt != r_hdr[DATA_W-1:ADDR_W]);
  end

  assign len_err = r_len_err;
`else
  assign len_err = 1'b0;
`endif

  assign dout             = r_dout;
  assign parity_done      = r_parity_done;
  assign low_packet_valid = r_low_packet_valid;
  assign err              = r_err;

endmodule

// File: tb/tb_router_reg_param.sv
// tb_router_reg_param: randomized packet-level bench for router_reg_param with a
// packet-level reference model (expected dout stream, XOR parity, payload count).
module tb_router_reg_param;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 2;
  localparam int NUM_PORTS = 3;
  localparam int FULL_CYC  = 2;

  logic              clock = 1'b0;
  logic              reset, pkt_valid, fifo_full, detect_add, lfd_state;
  logic              ld_state, laf_state, full_state, rst_int_reg;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] dout;
  logic              parity_done, low_packet_valid, err, len_err;

  int total = 0;
  int bad   = 0;

  router_reg_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .err(err), .len_err(len_err)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Observations captured by the packet driver
  logic [7:0] obs_q[$];
  logic       obs_pd_pre, obs_pd, obs_err_pre, obs_err, obs_err_hold, obs_lerr;
  logic       obs_lpv_set, obs_lpv_clr;
  logic [7:0] obs_r_dout;
  logic       obs_r_pd, obs_r_lpv, obs_r_err, obs_r_lerr;

  // Reference model state
  logic [7:0] m_hdr;
  logic [7:0] exp_q[$];
  logic       m_err, m_lerr;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; fifo_full = 0; detect_add = 0; lfd_state = 0; ld_state = 0;
    laf_state = 0; full_state = 0; rst_int_reg = 0; data_in = '0;
  endtask

  task automatic gen_pay(input int n, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] q[$]);
    logic [7:0] x = '0;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  function automatic logic [7:0] eff_hdr(input logic [7:0] hdr);
    return (int'(hdr[1:0]) < NUM_PORTS) ? hdr : m_hdr;
  endfunction

  // Packet-level model: header shown first, each word once; a parked word leaves dout
  // unchanged for the park cycle and the stall cycles, then appears on replay.
  function automatic void model_packet(input logic [7:0] hdr, input logic [7:0] pay[$],
                                       input logic [7:0] par, input int full_at);
    logic [7:0] words[$];
    int cnt;
    m_hdr = eff_hdr(hdr);
    words = pay;
    words.push_back(par);
    exp_q.delete();
    exp_q.push_back(m_hdr);
    foreach (words[i]) begin
      if (i == full_at) repeat (FULL_CYC + 1) exp_q.push_back(exp_q[exp_q.size()-1]);
      exp_q.push_back(words[i]);
    end
    m_err = ((m_hdr ^ xor_all(pay)) != par);
    cnt = (pay.size() > 63) ? 63 : pay.size();
`ifdef ROUTER_REG_LEN_CHECK_EN
    m_lerr = (cnt != int'(m_hdr[7:2]));
`else
    m_lerr = 1'b0;
`endif
  endfunction

  // Emulates the router FSM strobes for one packet and records what the DUT shows.
  task automatic drive_packet(input logic [7:0] hdr, input logic [7:0] pay[$],
                              input logic [7:0] par, input int full_at, input int rst_at);
    int n = pay.size();
    obs_q.delete();
    detect_add = 1; pkt_valid = 1; data_in = hdr; tick();
    detect_add = 0; lfd_state = 1; data_in = 8'($urandom); tick();
    obs_q.push_back(dout);
    lfd_state = 0;
    for (int i = 0; i <= n; i++) begin
      if (i == rst_at) begin
        reset = 1; ld_state = 1; pkt_valid = 1; data_in = pay[i]; tick();
        obs_r_dout = dout; obs_r_pd = parity_done; obs_r_lpv = low_packet_valid;
        obs_r_err = err; obs_r_lerr = len_err;
        reset = 0; idle_inputs();
        return;
      end
      ld_state = 1; pkt_valid = (i < n); data_in = (i < n) ? pay[i] : par;
      fifo_full = (i == full_at);
      if (i == n) obs_pd_pre = parity_done;
      tick();
      obs_q.push_back(dout);
      if (i == full_at) begin
        ld_state = 0; full_state = 1;
        for (int k = 0; k < FULL_CYC; k++) begin
          pkt_valid = 1'($urandom); data_in = 8'($urandom);
          fifo_full = (k < FULL_CYC - 1);
          tick();
          obs_q.push_back(dout);
        end
        full_state = 0; fifo_full = 0; laf_state = 1;
        if (i == n) obs_pd_pre = parity_done;
        tick();
        obs_q.push_back(dout);
        laf_state = 0;
      end
    end
    idle_inputs();
    obs_pd = parity_done; obs_err_pre = err;
    tick();
    obs_err = err; obs_lerr = len_err;
    tick();
    obs_err_hold = err; obs_lpv_set = low_packet_valid;
    rst_int_reg = 1; tick();
    obs_lpv_clr = low_packet_valid;
    rst_int_reg = 0;
  endtask

  task automatic test_reset();
    reset = 1; detect_add = 1; lfd_state = 1; ld_state = 1; laf_state = 1; full_state = 1;
    pkt_valid = 1; data_in = 8'h16;
    tick(); tick();
    total++; if (dout !== 8'h00)         begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (parity_done !== 1'b0)   begin bad++; $display("FAIL reset_pd got=%b exp=0", parity_done); end
    total++; if (low_packet_valid !== 1'b0) begin bad++; $display("FAIL reset_lpv got=%b exp=0", low_packet_valid); end
    total++; if (err !== 1'b0)           begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (len_err !== 1'b0)       begin bad++; $display("FAIL reset_len_err got=%b exp=0", len_err); end
    reset = 0; idle_inputs();
    m_hdr = '0;
  endtask

  task automatic test_good_packet();
    logic [7:0] pay[$];
    logic [7:0] par;
    gen_pay(5, pay);
    par = 8'h16 ^ xor_all(pay);
    model_packet(8'h16, pay, par, -1);
    drive_packet(8'h16, pay, par, -1, -1);
    foreach (exp_q[i]) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL good_dout[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (obs_pd_pre !== 1'b0) begin bad++; $display("FAIL good_pd_early got=%b exp=0", obs_pd_pre); end
    total++; if (obs_pd !== 1'b1)     begin bad++; $display("FAIL good_pd got=%b exp=1", obs_pd); end
    total++; if (obs_err !== m_err)   begin bad++; $display("FAIL good_err got=%b exp=%b", obs_err, m_err); end
    total++; if (obs_lerr !== m_lerr) begin bad++; $display("FAIL good_len_err got=%b exp=%b", obs_lerr, m_lerr); end
    total++; if (obs_lpv_set !== 1'b1) begin bad++; $display("FAIL good_lpv_set got=%b exp=1", obs_lpv_set); end
    total++; if (obs_lpv_clr !== 1'b0) begin bad++; $display("FAIL good_lpv_clr got=%b exp=0", obs_lpv_clr); end
  endtask

  task automatic test_bad_parity();
    logic [7:0] pay[$];
    do gen_pay(5, pay); while ((8'h16 ^ xor_all(pay)) == 8'h2E);
    model_packet(8'h16, pay, 8'h2E, -1);
    drive_packet(8'h16, pay, 8'h2E, -1, -1);
    total++; if (obs_q[6] !== 8'h2E)   begin bad++; $display("FAIL badpar_dout got=%h exp=2e", obs_q[6]); end
    total++; if (obs_err_pre !== 1'b0) begin bad++; $display("FAIL badpar_err_early got=%b exp=0", obs_err_pre); end
    total++; if (obs_err !== m_err)    begin bad++; $display("FAIL badpar_err got=%b exp=%b", obs_err, m_err); end
    total++; if (obs_err_hold !== m_err) begin bad++; $display("FAIL badpar_err_hold got=%b exp=%b", obs_err_hold, m_err); end
  endtask

  task automatic test_fifo_full_park();
    logic [7:0] pay[$];
    logic [7:0] par;
    gen_pay(5, pay);
    par = 8'h16 ^ xor_all(pay);
    model_packet(8'h16, pay, par, 2);
    drive_packet(8'h16, pay, par, 2, -1);
    foreach (exp_q[i]) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL park_dout[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (obs_err !== m_err)   begin bad++; $display("FAIL park_err got=%b exp=%b", obs_err, m_err); end
    total++; if (obs_lerr !== m_lerr) begin bad++; $display("FAIL park_len_err got=%b exp=%b", obs_lerr, m_lerr); end
  endtask

  task automatic test_parity_park();
    logic [7:0] pay[$];
    logic [7:0] par;
    gen_pay(5, pay);
    par = 8'h16 ^ xor_all(pay) ^ 8'h01;
    model_packet(8'h16, pay, par, 5);
    drive_packet(8'h16, pay, par, 5, -1);
    foreach (exp_q[i]) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL parpark_dout[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (obs_pd_pre !== 1'b0) begin bad++; $display("FAIL parpark_pd_early got=%b exp=0", obs_pd_pre); end
    total++; if (obs_pd !== 1'b1)     begin bad++; $display("FAIL parpark_pd got=%b exp=1", obs_pd); end
    total++; if (obs_err !== m_err)   begin bad++; $display("FAIL parpark_err got=%b exp=%b", obs_err, m_err); end
  endtask

  task automatic test_invalid_addr();
    logic [7:0] pay[$];
    logic [7:0] par;
    reset = 1; tick(); reset = 0;
    m_hdr = '0;
    gen_pay(5, pay);
    par = 8'h17 ^ xor_all(pay);
    model_packet(8'h17, pay, par, -1);
    drive_packet(8'h17, pay, par, -1, -1);
    total++; if (obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL inv_hdr_dout got=%h exp=%h", obs_q[0], exp_q[0]); end
    total++; if (obs_err !== m_err)     begin bad++; $display("FAIL inv_err got=%b exp=%b", obs_err, m_err); end
    total++; if (obs_lerr !== m_lerr)   begin bad++; $display("FAIL inv_len_err got=%b exp=%b", obs_lerr, m_lerr); end
  endtask

  task automatic test_len_mismatch();
    logic [7:0] pay[$];
    logic [7:0] par;
    gen_pay(3, pay);
    par = 8'h16 ^ xor_all(pay);
    model_packet(8'h16, pay, par, -1);
    drive_packet(8'h16, pay, par, -1, -1);
    total++; if (obs_lerr !== m_lerr) begin bad++; $display("FAIL len_mis_len_err got=%b exp=%b", obs_lerr, m_lerr); end
    total++; if (obs_err !== m_err)   begin bad++; $display("FAIL len_mis_err got=%b exp=%b", obs_err, m_err); end
  endtask

  task automatic test_saturate();
    logic [7:0] pay[$];
    logic [7:0] par;
    int counts[2] = '{70, 62};
    foreach (counts[c]) begin
      gen_pay(counts[c], pay);
      par = 8'hFD ^ xor_all(pay);
      model_packet(8'hFD, pay, par, -1);
      drive_packet(8'hFD, pay, par, -1, -1);
      total++; if (obs_lerr !== m_lerr) begin bad++; $display("FAIL sat_len_err[%0d] got=%b exp=%b", counts[c], obs_lerr, m_lerr); end
      total++; if (obs_err !== m_err)   begin bad++; $display("FAIL sat_err[%0d] got=%b exp=%b", counts[c], obs_err, m_err); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pay[$];
    logic [7:0] par;
    gen_pay(4, pay);
    par = ~(8'h16 ^ xor_all(pay));
    model_packet(8'h16, pay, par, -1);
    drive_packet(8'h16, pay, par, -1, -1);
    total++; if (obs_err !== m_err) begin bad++; $display("FAIL rst_pre_err got=%b exp=%b", obs_err, m_err); end
    reset = 1; tick(); reset = 0;
    m_hdr = '0;
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL rst_idle_err got=%b exp=0", err); end
    total++; if (len_err !== 1'b0) begin bad++; $display("FAIL rst_idle_len_err got=%b exp=0", len_err); end
    gen_pay(5, pay);
    drive_packet(8'h16, pay, 8'h00, -1, 1);
    m_hdr = '0;
    total++; if (obs_r_dout !== 8'h00) begin bad++; $display("FAIL rst_mid_dout got=%h exp=00", obs_r_dout); end
    total++; if (obs_r_pd !== 1'b0)    begin bad++; $display("FAIL rst_mid_pd got=%b exp=0", obs_r_pd); end
    total++; if (obs_r_lpv !== 1'b0)   begin bad++; $display("FAIL rst_mid_lpv got=%b exp=0", obs_r_lpv); end
    total++; if (obs_r_err !== 1'b0)   begin bad++; $display("FAIL rst_mid_err got=%b exp=0", obs_r_err); end
    total++; if (obs_r_lerr !== 1'b0)  begin bad++; $display("FAIL rst_mid_len_err got=%b exp=0", obs_r_lerr); end
    gen_pay(5, pay);
    par = 8'h16 ^ xor_all(pay);
    model_packet(8'h16, pay, par, -1);
    drive_packet(8'h16, pay, par, -1, -1);
    foreach (exp_q[i]) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rst_after_dout[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (obs_err !== m_err)   begin bad++; $display("FAIL rst_after_err got=%b exp=%b", obs_err, m_err); end
    total++; if (obs_lerr !== m_lerr) begin bad++; $display("FAIL rst_after_len_err got=%b exp=%b", obs_lerr, m_lerr); end
  endtask

  task automatic test_random();
    logic [7:0] pay[$];
    logic [7:0] hdr, par;
    int n, full_at;
    for (int p = 0; p < 10; p++) begin
      hdr = {6'($urandom_range(0, 12)), 2'($urandom_range(0, 3))};
      n = ($urandom_range(0, 2) != 0) ? int'(eff_hdr(hdr) >> 2) : $urandom_range(0, 12);
      gen_pay(n, pay);
      full_at = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, n);
      par = eff_hdr(hdr) ^ xor_all(pay);
      if ($urandom_range(0, 1) == 1) par ^= 8'($urandom_range(1, 255));
      model_packet(hdr, pay, par, full_at);
      drive_packet(hdr, pay, par, full_at, -1);
      foreach (exp_q[i]) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_dout[%0d] got=%h exp=%h", p, i, obs_q[i], exp_q[i]); end
      end
      total++; if (obs_pd !== 1'b1)     begin bad++; $display("FAIL rand%0d_pd got=%b exp=1", p, obs_pd); end
      total++; if (obs_err !== m_err)   begin bad++; $display("FAIL rand%0d_err got=%b exp=%b", p, obs_err, m_err); end
      total++; if (obs_lerr !== m_lerr) begin bad++; $display("FAIL rand%0d_len_err got=%b exp=%b", p, obs_lerr, m_lerr); end
    end
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    m_hdr = '0;
    repeat (2) tick();
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_fifo_full_park();
    test_parity_park();
    test_invalid_addr();
    test_len_mismatch();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_reg_param.md
# router_reg_param

Parametrised successor to the router's input register stage: latches the packet header, forwards header/payload/parity to the selected output FIFO, parks one byte while the destination FIFO is full and replays it, computes running XOR parity and flags parity errors. Generalised over data width and output-port count, and optionally checks the header's payload-length field against the bytes actually received. Sits between the router FSM (which drives the state strobes) and the output FIFOs (which consume `dout`).

## Interface

Parameters:
- `DATA_W`, 8: width of every packet word; header = {payload_len[DATA_W-1:ADDR_W], addr[ADDR_W-1:0]}.
- `ADDR_W`, 2: width of the address field.
- `NUM_PORTS`, 3: number of valid destinations; addr ≥ NUM_PORTS is invalid. Must satisfy NUM_PORTS ≤ 2^ADDR_W.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  **one clock; reset is synchronous and active-high**.
- `pkt_valid`  in  1  high for header and payload words, low on the parity word.
- `data_in`  in  DATA_W  packet word.
- `fifo_full`  in  1  destination FIFO full.
- `detect_add`  in  1  FSM in DECODE_ADDRESS.
- `lfd_state`  in  1  FSM in LOAD_FIRST_DATA.
- `ld_state`  in  1  FSM in LOAD_DATA.
- `laf_state`  in  1  FSM in LOAD_AFTER_FULL.
- `full_state`  in  1  FSM in FIFO_FULL_STATE.
- `rst_int_reg`  in  1  clears `low_packet_valid`.
- `dout`  out  DATA_W  word to output FIFO.
- `parity_done`  out  1  parity word captured.
- `low_packet_valid`  out  1  parity word seen while loading.
- `err`  out  1  parity mismatch.
- `len_err`  out  1  payload count ≠ header length (0 when feature compiled out).

## Operation

Internal registers: `hdr` (DATA_W), `hold` (DATA_W), `int_par` (DATA_W), `pkt_par` (DATA_W), `pay_cnt` (DATA_W-ADDR_W bits, saturating).
- Header latch: `detect_add && pkt_valid && data_in[ADDR_W-1:0] < NUM_PORTS` → `hdr <= data_in`. Invalid address leaves `hdr` unchanged.
- `dout`: `lfd_state` → `hdr`; `ld_state && !fifo_full` → `data_in`; `laf_state` → `hold`; otherwise holds.
- `hold`: `ld_state && fifo_full` → `hold <= data_in` (one-word park).
- `int_par`: cleared on `detect_add`; `lfd_state` → `int_par ^ hdr`; `ld_state && pkt_valid && !full_state` → `int_par ^ data_in`.
- `pkt_par`: captured from `data_in` when `ld_state && !pkt_valid && !fifo_full`; captured from `hold` when `laf_state && low_packet_valid && !parity_done`.
- `parity_done`: set under the same two capture conditions; cleared on `detect_add`.
- `low_packet_valid`: set on `ld_state && !pkt_valid`; cleared on `rst_int_reg`.
- `err`: when `parity_done` is high, `err <= (int_par != pkt_par)`; cleared on `detect_add`.
- Priority per register: `reset` > `detect_add` > `rst_int_reg` > data conditions.
- Parked word replayed via `laf_state` is a payload word: it is XORed into `int_par` when it was parked under `ld_state && pkt_valid`.

## Timing

- All outputs registered; every update visible one clock after the qualifying edge.
- `reset` high at a rising edge: all outputs and internal registers 0 next cycle, regardless of strobes; reset mid-packet abandons the packet, with no residual `err`/`len_err`.
- Header to `dout`: `detect_add` cycle N, `lfd_state` cycle N+1, `dout = hdr` after edge N+1.
- `parity_done` rises one cycle after the parity word is captured; `err`/`len_err` valid one cycle after `parity_done` rises and hold until next `detect_add` or reset.
- Simultaneous `ld_state && fifo_full` on the parity word: `pkt_par` taken later from `hold` in `laf_state`.
- `pay_cnt` saturates at all-ones; never wraps.

## Configuration

- `ROUTER_REG_LEN_CHECK_EN` defined: `pay_cnt` cleared on `detect_add` and incremented on each payload word accepted (`ld_state && pkt_valid && !full_state`). When `parity_done` is high, `len_err <= (pay_cnt != hdr[DATA_W-1:ADDR_W])`.
- Macro undefined: `pay_cnt` is not built and `len_err` is tied to 0.

## Test plan

All scenarios use DATA_W=8, ADDR_W=2, NUM_PORTS=3, and the macro defined.
- Reset, then good packet: header 0x16 (len 5, addr 2), 5 random payloads, correct XOR parity → `dout` sequence 0x16, payloads, parity; `parity_done`=1; `err`=0; `len_err`=0.
- Same packet with parity word 46 (0x2E), where true parity ≠ 0x2E → `err`=1 one cycle after `parity_done`.
- `fifo_full`=1 during 3rd payload under `ld_state` → byte parked in `hold`; emitted on `dout` in the `laf_state` cycle; final `err`=0.
- Header 0x17 (addr 3) under `detect_add`, followed by `lfd_state` → `dout` shows the previous `hdr` (0 after reset).
- Header 0x16 with pkt_valid dropping after 3 payloads → `len_err`=1, `err` per parity.
- `reset` asserted during 2nd payload → all outputs 0 next cycle; the following good packet completes with `err`=0.
